speed_test_sequencer: RTL and testbench
=======================================

SPEED_TEST_SEQUENCER -- requirements
Module: speed_test_sequencer

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 2: cycles between arming and the fired-bit pre-check (1..15).
REQ-002 SHALL have parameter WAIT_CYCLES, default 3: cycles after trigger release before the fired-bit check (1..15).
REQ-003 SHALL have parameter MIN_COUNT, default 10: lowest acceptable raw count value.
REQ-004 SHALL have parameter MAX_DIFF, default 3: largest acceptable |count0-count1|.
REQ-005 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-006 SHALL have port nrst, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port start, input, 1: single-cycle measurement request.
REQ-008 SHALL have port abort, input, 1: synchronous abort of a running sequence.
REQ-009 SHALL have port dut_out, input, 8: speed-test io_out (bit6 = fired, bits7:0 = readout byte).
REQ-010 SHALL have port dut_nrst, output, 1: speed-test reset.
REQ-011 SHALL have port trig, output, 1: speed-test trigger.
REQ-012 SHALL have port sel, output, 3: speed-test readout select.
REQ-013 SHALL have port ring_en, output, 2: ring-oscillator enables.
REQ-014 SHALL have ports busy, done, pass, outputs, 1 each: sequence active, one-cycle completion pulse, result valid-and-good.
REQ-015 SHALL have port err_code, output, 3: failure reason; also ports count0 and count1, outputs, 24 each: captured counts.

Function
REQ-016 SHALL implement states IDLE, ARM, SETTLE, FIRE, WAIT, RING_OFF, READ, EVAL, DONE.
REQ-017 SHALL leave IDLE only on start=1: IDLE outputs dut_nrst=0, trig=0, sel=000, ring_en=00, busy=0.
REQ-018 SHALL ignore start while busy=1.
REQ-019 SHALL, in ARM (1 cycle), drive dut_nrst=1, ring_en=11, sel=111, busy=1; these values hold through WAIT.
REQ-020 SHALL hold SETTLE for SETTLE_CYCLES cycles, then sample dut_out[6]: 1 -> err_code=1 (fired early), go to EVAL without reading; 0 -> go to FIRE.
REQ-021 SHALL drive trig=1 for exactly 2 cycles in FIRE, then trig=0.
REQ-022 SHALL hold WAIT for WAIT_CYCLES cycles, then sample dut_out[6]: 0 -> err_code=2 (no fire), go to EVAL; 1 -> go to RING_OFF.
REQ-023 SHALL drive ring_en=00 from RING_OFF (1 cycle) until the next ARM.
REQ-024 SHALL, in READ, step sel through 000,001,010,100,101,110, holding each for 2 cycles and capturing dut_out on the second cycle into count0[7:0], [15:8], [23:16], count1[7:0], [15:8], [23:16] respectively (12 cycles total).
REQ-025 SHALL, in EVAL (1 cycle), set err_code by first failing check in priority: count0<MIN_COUNT ->3; count1<MIN_COUNT ->4; |count0-count1|>MAX_DIFF ->5 (25-bit unsigned difference, no wrap); count0[23]==0 ->6; count1[23]==0 ->7; else 0.
REQ-026 SHALL keep an error from REQ-020/022 unchanged through EVAL.
REQ-027 SHALL, in DONE (1 cycle), assert done=1, pass=(err_code==0), busy=0, then return to IDLE.
REQ-028 SHALL hold pass, err_code, count0, count1 until the next ARM, where pass clears; counts are not cleared on errors.
REQ-029 SHALL assert done on the (18+SETTLE_CYCLES+WAIT_CYCLES)th rising edge after start is sampled on a passing run (23 with defaults).
REQ-030 SHALL, on abort=1 in any non-IDLE state, go to IDLE next cycle without done, with trig=0, ring_en=00, and pass/err_code/counts unchanged.
REQ-031 SHALL give abort priority over any state transition in the same cycle, including entry to DONE.

Reset
REQ-032 SHALL, on nrst=0, immediately force IDLE with dut_nrst=0, trig=0, sel=000, ring_en=00, busy=0, done=0, pass=0, err_code=000, count0=count1=0.
REQ-033 SHALL resume only on a start sampled after nrst deasserts.

Verification
REQ-034 SHALL pass: model returns fired=1 and counts FFFF00/FFFF02 -> done at edge 23, pass=1, err_code=0, count0=FFFF00, count1=FFFF02.
REQ-035 SHALL pass: fired bit stuck 0 -> err_code=2, pass=0, sel never leaves 111, ring_en=00 after WAIT.
REQ-036 SHALL pass: counts 800000/800004 -> err_code=5; counts 7FFFF0/7FFFF0 -> err_code=6.
REQ-037 SHALL pass: fired bit 1 before trigger -> err_code=1, trig never asserted.
REQ-038 SHALL pass: abort during READ -> no done, IDLE outputs next cycle, prior results retained.
REQ-039 SHALL pass: nrst pulsed low mid-FIRE -> trig=0 and all outputs at reset values without a clock edge.

Source files
------------

// File: rtl/speed_test_sequencer.sv
// Sequencer for the ring-oscillator speed test: arm, settle, fire, wait, read back
// two 24-bit counts through the byte-wide readout mux, then grade the result.
module speed_test_sequencer #(
  parameter int SETTLE_CYCLES = 2,
  parameter int WAIT_CYCLES   = 3,
  parameter int MIN_COUNT     = 10,
  parameter int MAX_DIFF      = 3
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        start,
  input  logic        abort,
  input  logic [7:0]  dut_out,
  output logic        dut_nrst,
  output logic        trig,
  output logic [2:0]  sel,
  output logic [1:0]  ring_en,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [2:0]  err_code,
  output logic [23:0] count0,
  output logic [23:0] count1
);

  typedef enum logic [3:0] {
    S_IDLE, S_ARM, S_SETTLE, S_FIRE, S_WAIT, S_RING_OFF, S_READ, S_EVAL, S_DONE
  } state_t;

  localparam logic [3:0]  SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [3:0]  WAIT_LAST   = 4'(WAIT_CYCLES - 1);
  localparam logic [23:0] MIN_C       = 24'(MIN_COUNT);
  localparam logic [24:0] MAX_D       = 25'(MAX_DIFF);

  state_t      state, state_nx;
  logic [3:0]  cnt;
  logic [2:0]  run_err, run_err_nx;
  logic [23:0] cap0, cap1;
  logic [24:0] diff;
  logic [2:0]  eval_err;
  logic [2:0]  rd_idx;

  always_comb begin
    state_nx   = state;
    run_err_nx = run_err;
    case (state)
      S_IDLE:     if (start) state_nx = S_ARM;
      S_ARM:      state_nx = S_SETTLE;
      S_SETTLE:   if (cnt == SETTLE_LAST) begin
                    if (dut_out[6]) begin
                      run_err_nx = 3'd1;
                      state_nx   = S_EVAL;
                    end else begin
                      state_nx = S_FIRE;
                    end
                  end
      S_FIRE:     if (cnt == 4'd1) state_nx = S_WAIT;
      S_WAIT:     if (cnt == WAIT_LAST) begin
                    if (!dut_out[6]) begin
                      run_err_nx = 3'd2;
                      state_nx   = S_EVAL;
                    end else begin
                      state_nx = S_RING_OFF;
                    end
                  end
      S_RING_OFF: state_nx = S_READ;
      S_READ:     if (cnt == 4'd11) state_nx = S_EVAL;
      S_EVAL:     state_nx = S_DONE;
      S_DONE:     state_nx = S_IDLE;
      default:    state_nx = S_IDLE;
    endcase
    // abort outranks every transition, including the one into DONE
    if (abort && state != S_IDLE) state_nx = S_IDLE;
  end

  // readout select skips 011: bytes 0..2 of count0 on 000..010, count1 on 100..110
  assign rd_idx = cnt[3:1];

  always_comb begin
    dut_nrst = (state != S_IDLE);
    trig     = (state == S_FIRE);
    busy     = (state != S_IDLE) && (state != S_DONE);
    done     = (state == S_DONE);
    ring_en  = (state == S_ARM || state == S_SETTLE || state == S_FIRE || state == S_WAIT)
               ? 2'b11 : 2'b00;
    if (state == S_IDLE)      sel = 3'b000;
    else if (state == S_READ) sel = (rd_idx >= 3'd3) ? rd_idx + 3'd1 : rd_idx;
    else                      sel = 3'b111;
  end

  always_comb begin
    diff = (cap0 >= cap1) ? ({1'b0, cap0} - {1'b0, cap1}) : ({1'b0, cap1} - {1'b0, cap0});
    if (run_err != 3'd0)  eval_err = run_err;
    else if (cap0 < MIN_C) eval_err = 3'd3;
    else if (cap1 < MIN_C) eval_err = 3'd4;
    else if (diff > MAX_D) eval_err = 3'd5;
    else if (!cap0[23])    eval_err = 3'd6;
    else if (!cap1[23])    eval_err = 3'd7;
    else                   eval_err = 3'd0;
  end

  // counts are staged in cap0/cap1 so an aborted read leaves the last results visible
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      run_err  <= '0;
      cap0     <= '0;
      cap1     <= '0;
      pass     <= 1'b0;
      err_code <= '0;
      count0   <= '0;
      count1   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= (state_nx != state) ? 4'd0 : cnt + 4'd1;
      if (state == S_IDLE && state_nx == S_ARM) begin
        run_err <= '0;
        pass    <= 1'b0;
      end else begin
        run_err <= run_err_nx;
      end
      if (state == S_READ && cnt[0]) begin
        case (rd_idx)
          3'd0:    cap0[7:0]   <= dut_out;
          3'd1:    cap0[15:8]  <= dut_out;
          3'd2:    cap0[23:16] <= dut_out;
          3'd3:    cap1[7:0]   <= dut_out;
          3'd4:    cap1[15:8]  <= dut_out;
          3'd5:    cap1[23:16] <= dut_out;
          default: ;
        endcase
      end
      if (state == S_EVAL && state_nx == S_DONE) begin
        err_code <= eval_err;
        pass     <= (eval_err == 3'd0);
        if (run_err == 3'd0) begin
          count0 <= cap0;
          count1 <= cap1;
        end
      end
    end
  end

endmodule

// File: tb/tb_speed_test_sequencer.sv
// Randomized bench for speed_test_sequencer: a timeline model of each run predicts
// every control output per cycle and the graded results at DONE.
module tb_speed_test_sequencer;
  localparam int S = 2;
  localparam int W = 3;
  localparam int MINC = 10;
  localparam int MAXD = 3;

  logic        clk, nrst, start, abort;
  logic [7:0]  dut_out;
  logic        dut_nrst, trig, busy, done, pass;
  logic [2:0]  sel, err_code;
  logic [1:0]  ring_en;
  logic [23:0] count0, count1;

  speed_test_sequencer #(.SETTLE_CYCLES(S), .WAIT_CYCLES(W), .MIN_COUNT(MINC), .MAX_DIFF(MAXD)) u_dut (
    .clk(clk), .nrst(nrst), .start(start), .abort(abort), .dut_out(dut_out),
    .dut_nrst(dut_nrst), .trig(trig), .sel(sel), .ring_en(ring_en),
    .busy(busy), .done(done), .pass(pass), .err_code(err_code),
    .count0(count0), .count1(count1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // speed-test macro model: mode 0 fires after trigger, 1 never fires, 2 fires immediately
  int          md;
  logic        fired;
  logic [23:0] m_c0, m_c1;
  logic        fbit;

  always_comb begin
    fbit = (md == 2) ? 1'b1 : ((md == 0) ? fired : 1'b0);
    case (sel)
      3'b000:  dut_out = m_c0[7:0];
      3'b001:  dut_out = m_c0[15:8];
      3'b010:  dut_out = m_c0[23:16];
      3'b100:  dut_out = m_c1[7:0];
      3'b101:  dut_out = m_c1[15:8];
      3'b110:  dut_out = m_c1[23:16];
      default: dut_out = {1'b0, fbit, 6'b0};
    endcase
  end

  int n_total = 0;
  int n_pass  = 0;
  int cur_k   = 0;

  // visible results the model expects to be held
  logic        e_pass;
  logic [2:0]  e_err;
  logic [23:0] e_c0, e_c1;

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    n_total++;
    if (a === e) n_pass++;
    else $display("FAIL %s k=%0d actual=%0h required=%0h", nm, cur_k, a, e);
  endtask

  function automatic int model_err(int mode, logic [23:0] c0, logic [23:0] c1);
    longint a, b, d;
    a = longint'(c0);
    b = longint'(c1);
    d = (a > b) ? a - b : b - a;
    if (mode == 2) return 1;
    if (mode == 1) return 2;
    if (a < MINC) return 3;
    if (b < MINC) return 4;
    if (d > MAXD) return 5;
    if (a < 64'h800000) return 6;
    if (b < 64'h800000) return 7;
    return 0;
  endfunction

  function automatic logic [8:0] idle_ctl();
    return 9'b0;
  endfunction

  task automatic chk_ctl(input string nm, input logic [8:0] e);
    chk(nm, 64'({dut_nrst, trig, sel, ring_en, busy, done}), 64'(e));
  endtask

  task automatic chk_res(input string nm);
    chk(nm, 64'({pass, err_code, count0, count1}), 64'({e_pass, e_err, e_c0, e_c1}));
  endtask

  // one measurement; abort_at>0 aborts during that cycle, mid_start>0 pulses start while busy
  task automatic run(input int mode, input logic [23:0] c0, input logic [23:0] c1,
                     input int abort_at, input int mid_start, output int done_k);
    int L, ring_last, err, k, idx;
    logic [2:0] s_exp;
    logic       t_exp;
    int tbl[6] = '{0, 1, 2, 4, 5, 6};
    md = mode; m_c0 = c0; m_c1 = c1; fired = 1'b0;
    L = (mode == 2) ? S + 3 : (mode == 1) ? S + W + 5 : S + W + 18;
    ring_last = (mode == 2) ? S + 1 : S + W + 3;
    err = model_err(mode, c0, c1);
    done_k = -1;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    e_pass = 1'b0;
    k = 1;
    while (k <= L + 2) begin
      @(negedge clk);
      cur_k = k;
      if (done) done_k = k;
      if (abort_at > 0 && k == abort_at + 1) begin
        chk_ctl("abort_idle", idle_ctl());
        chk_res("abort_held");
        break;
      end
      if (k <= L) begin
        t_exp = (mode != 2) && k >= S + 2 && k <= S + 3;
        idx   = (k - (S + W + 5)) / 2;
        s_exp = (mode == 0 && k >= S + W + 5 && k <= S + W + 16) ? 3'(tbl[idx]) : 3'b111;
        chk_ctl("run_ctl", {1'b1, t_exp, s_exp, (k <= ring_last) ? 2'b11 : 2'b00,
                            k < L, k == L});
        if (k < L) chk("pass_clr", 64'(pass), 64'(0));
        else begin
          e_pass = (err == 0);
          e_err  = 3'(err);
          if (mode == 0) begin e_c0 = c0; e_c1 = c1; end
          chk_res("done_res");
        end
      end else begin
        chk_ctl("idle_ctl", idle_ctl());
        chk_res("idle_held");
      end
      if (trig) fired = 1'b1;
      abort = (k == abort_at);
      start = (k == mid_start);
      @(posedge clk); #1 abort = 1'b0; start = 1'b0;
      k++;
    end
  endtask

  initial begin
    int dk, mode, ab, ms, L;
    logic [23:0] a, b;
    nrst = 1'b0; start = 1'b0; abort = 1'b0;
    md = 0; fired = 1'b0; m_c0 = '0; m_c1 = '0;
    e_pass = 1'b0; e_err = '0; e_c0 = '0; e_c1 = '0;
    repeat (2) @(negedge clk);
    chk_ctl("reset_ctl", idle_ctl());
    chk_res("reset_res");
    nrst = 1'b1;
    repeat (2) @(negedge clk);
    chk_ctl("idle_after_reset", idle_ctl());

    // passing reference run
    run(0, 24'hFFFF00, 24'hFFFF02, 0, 0, dk);
    chk("done_edge", 64'(dk), 64'(23));
    chk("pass_lit", 64'(pass), 64'(1));
    chk("err_lit0", 64'(err_code), 64'(0));
    chk("c0_lit", 64'(count0), 64'h00FFFF00);
    chk("c1_lit", 64'(count1), 64'h00FFFF02);

    run(1, 24'h123456, 24'h123456, 0, 0, dk);
    chk("err_nofire", 64'(err_code), 64'(2));
    chk("counts_kept", 64'(count0), 64'h00FFFF00);
    run(0, 24'h800000, 24'h800004, 0, 0, dk);
    chk("err_diff", 64'(err_code), 64'(5));
    run(0, 24'h7FFFF0, 24'h7FFFF0, 0, 0, dk);
    chk("err_msb", 64'(err_code), 64'(6));
    run(2, 24'h0, 24'h0, 0, 0, dk);
    chk("err_early", 64'(err_code), 64'(1));
    chk("done_early", 64'(dk), 64'(S + 3));

    run(0, 24'h900010, 24'h900011, 0, 0, dk);
    run(0, 24'hABCDEF, 24'h111111, S + W + 8, 0, dk);
    chk("abort_no_done", 64'(dk), 64'(-1));
    chk("abort_c0", 64'(count0), 64'h00900010);

    for (int r = 0; r < 24; r++) begin
      mode = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 2)) : 0;
      case ($urandom_range(0, 3))
        0: a = 24'($urandom_range(0, 15));
        1: a = 24'($urandom);
        default: a = 24'h800000 | 24'($urandom_range(0, 24'h7FFFFF));
      endcase
      b = ($urandom_range(0, 2) == 0) ? 24'($urandom) : a + 24'($urandom_range(0, 8)) - 24'd4;
      L = (mode == 2) ? S + 3 : (mode == 1) ? S + W + 5 : S + W + 18;
      ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, L - 1)) : 0;
      ms = ($urandom_range(0, 2) == 0) ? 3 : 0;
      run(mode, a, b, ab, ms, dk);
    end

    // reset pulse during FIRE, checked with no clock edge in between
    md = 0; fired = 1'b0; m_c0 = 24'h0; m_c1 = 24'h0;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (S + 2) @(negedge clk);
    cur_k = S + 2;
    chk("fire_trig", 64'(trig), 64'(1));
    #1 nrst = 1'b0;
    #1;
    e_pass = 1'b0; e_err = '0; e_c0 = '0; e_c1 = '0;
    chk_ctl("async_rst_ctl", idle_ctl());
    chk_res("async_rst_res");
    #1 nrst = 1'b1;
    repeat (2) @(negedge clk);
    chk_ctl("post_rst_idle", idle_ctl());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout k=%0d", cur_k);
    $fatal(1, "timeout");
  end
endmodule
